// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Brief    : Shared types, sizes and address helpers for the 2-way cache
//             controller and its way storage.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int AW         = 6;
  localparam int DW         = 32;
  localparam int LINE_WORDS = 4;
  localparam int SETS       = 4;
  localparam int OFF_W      = 2;
  localparam int IDX_W      = 2;
  localparam int TAG_W      = AW - IDX_W - OFF_W;
  localparam int LINE_W     = LINE_WORDS * DW;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TAG  = 3'd1,
    ST_FILL = 3'd2,
    ST_WMEM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [AW-1:0] a);
    return a[AW-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [AW-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  // Block-aligned address of the line holding a
  function automatic logic [AW-1:0] block_addr(input logic [AW-1:0] a);
    return {addr_tag(a), addr_idx(a), {OFF_W{1'b0}}};
  endfunction

  // Word 0 of a line lives in the most-significant slice
  function automatic logic [DW-1:0] line_get(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  off);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (off == OFF_W'(LINE_WORDS - 1 - i)) w = line[i*DW +: DW];
    end
    return w;
  endfunction

  function automatic logic [LINE_W-1:0] line_put(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [DW-1:0]     word);
    logic [LINE_W-1:0] l;
    l = line;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (off == OFF_W'(LINE_WORDS - 1 - i)) l[i*DW +: DW] = word;
    end
    return l;
  endfunction

  // Saturating counter increment: holds at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_2way_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_cpu_if / cache_mem_if
//  Brief    : CPU-side request bus and Mem-side block-read / word-write bus
//             of the 2-way cache controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_cpu_if;
  import cache_pkg::*;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_ready);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_ready);
endinterface

interface cache_mem_if;
  import cache_pkg::*;

  logic [AW-1:0]     mem_raddr;
  logic [LINE_W-1:0] mem_rdata;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_CS;
  logic              mem_RW;

  modport master (output mem_raddr, mem_waddr, mem_wdata, mem_CS, mem_RW,
                  input  mem_rdata);
  modport slave  (input  mem_raddr, mem_waddr, mem_wdata, mem_CS, mem_RW,
                  output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/cache_way.sv
`default_nettype none
// ============================================================================
//  Module   : cache_way
//  Brief    : One way of the cache: per-set valid bit, tag and 4-word line,
//             with an asynchronous tag/word read port, a full-line fill port
//             and a single-word write port.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_way
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DW-1:0]     word_o,
  input  logic              fill_en_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [DW-1:0]     wr_data_i
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Valid bits are the only state that needs clearing; a fill sets one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tag and data are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i] <= line_put(data_q[wr_idx_i], wr_off_i, wr_data_i);
    end
  end

  assign valid_o = valid_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign word_o  = line_get(data_q[rd_idx_i], rd_off_i);

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_2way
//  Brief    : 2-way set-associative write-through, no-write-allocate cache
//             controller. Refills whole lines from a 128b Mem block read,
//             forwards every store as a single word write, keeps LRU state
//             and saturating hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_2way
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cache_cpu_if.slave       cpu,
  cache_mem_if.master      mem,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_t           state_q, state_d;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic [SETS-1:0]  lru_q;      // per set: index of the least recently used way
  logic             hit_way_q;
  logic             store_hit_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [OFF_W-1:0] w_off;
  logic [1:0]       w_valid;
  logic [1:0]       w_hit;
  logic [1:0]       w_fill_en;
  logic [1:0]       w_wr_en;
  logic [TAG_W-1:0] w_way_tag  [2];
  logic [DW-1:0]    w_way_word [2];
  logic             w_any_hit;
  logic             w_hit_way;
  logic             w_victim;

  logic             w_ready;
  logic             w_cs;
  logic             w_rw;
  logic [AW-1:0]    w_raddr;
  logic [AW-1:0]    w_waddr;
  logic [DW-1:0]    w_wdata;

  assign w_idx = addr_idx(addr_q);
  assign w_tag = addr_tag(addr_q);
  assign w_off = addr_off(addr_q);

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way u_way (
      .clk         (clk),
      .reset       (reset),
      .rd_idx_i    (w_idx),
      .rd_off_i    (w_off),
      .valid_o     (w_valid[g]),
      .tag_o       (w_way_tag[g]),
      .word_o      (w_way_word[g]),
      .fill_en_i   (w_fill_en[g]),
      .fill_idx_i  (w_idx),
      .fill_tag_i  (w_tag),
      .fill_line_i (mem.mem_rdata),
      .wr_en_i     (w_wr_en[g]),
      .wr_idx_i    (w_idx),
      .wr_off_i    (w_off),
      .wr_data_i   (wdata_q)
    );
  end

  // Tag compare, victim selection and way write strobes
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 2; i++) begin
      w_hit[i] = w_valid[i] && (w_way_tag[i] == w_tag);
    end
    w_any_hit = |w_hit;
    // Fills happen only on a miss, so at most one way can match
    w_hit_way = !w_hit[0];
    if (!w_valid[0])      w_victim = 1'b0;
    else if (!w_valid[1]) w_victim = 1'b1;
    else                  w_victim = lru_q[w_idx];
    w_fill_en = '0;
    w_wr_en   = '0;
    w_fill_en[w_victim] = (state_q == ST_FILL);
    w_wr_en[hit_way_q]  = (state_q == ST_WMEM) && store_hit_q;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cpu.cpu_req) state_d = ST_TAG;
      ST_TAG: begin
        if (we_q)           state_d = ST_WMEM;
        else if (w_any_hit) state_d = ST_DONE;
        else                state_d = ST_FILL;
      end
      ST_FILL: state_d = ST_DONE;
      ST_WMEM: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; everything idles at zero
  always_comb begin
    w_ready = 1'b0;
    w_cs    = 1'b0;
    w_rw    = 1'b0;
    w_raddr = '0;
    w_waddr = '0;
    w_wdata = '0;
    unique case (state_q)
      ST_FILL: begin
        w_cs    = 1'b1;
        w_raddr = block_addr(addr_q);
      end
      ST_WMEM: begin
        w_cs    = 1'b1;
        w_rw    = 1'b1;
        w_waddr = addr_q;
        w_wdata = wdata_q;
      end
      ST_DONE: w_ready = 1'b1;
      default: ;
    endcase
  end

  // Request latch, load data, LRU update and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      lru_q       <= '0;
      hit_way_q   <= 1'b0;
      store_hit_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpu.cpu_req) begin
            we_q    <= cpu.cpu_we;
            addr_q  <= cpu.cpu_addr;
            wdata_q <= cpu.cpu_wdata;
          end
        end
        ST_TAG: begin
          if (w_any_hit) hit_q  <= sat_inc(hit_q);
          else           miss_q <= sat_inc(miss_q);
          hit_way_q   <= w_hit_way;
          store_hit_q <= w_any_hit;
          if (!we_q && w_any_hit) begin
            rdata_q      <= w_way_word[w_hit_way];
            lru_q[w_idx] <= ~w_hit_way;
          end
        end
        ST_FILL: begin
          rdata_q      <= line_get(mem.mem_rdata, w_off);
          lru_q[w_idx] <= ~w_victim;
        end
        ST_WMEM: begin
          if (store_hit_q) lru_q[w_idx] <= ~hit_way_q;
        end
        default: ;
      endcase
    end
  end

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ready = w_ready;
  assign mem.mem_CS    = w_cs;
  assign mem.mem_RW    = w_rw;
  assign mem.mem_raddr = w_raddr;
  assign mem.mem_waddr = w_waddr;
  assign mem.mem_wdata = w_wdata;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_ctrl_2way
//  Brief    : Self-checking bench for cache_ctrl_2way with a 64 x 32b Mem
//             model, a vector table of loads/stores and reset corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_2way;
  import cache_pkg::*;

  logic             clk;
  logic             reset;
  logic             mem_load;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [DW-1:0]    mem_arr [64];

  int total;
  int bad;
  int exp_hits;
  int exp_misses;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          hit;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    int            lat;
    int            cs_cycles;
    logic          fill;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [15:0]   hits;
    logic [15:0]   misses;
  } exp_t;

  exp_t sb [$];

  cache_cpu_if cpu_bus ();
  cache_mem_if mem_bus ();

  cache_ctrl_2way dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_init(input int i);
    case (i)
      8'h08:   return 32'h0000_0011;
      8'h09:   return 32'h0000_0022;
      8'h0A:   return 32'h0000_0033;
      8'h0B:   return 32'h0000_0044;
      8'h18:   return 32'h0000_1818;
      8'h28:   return 32'h0000_2828;
      default: return 32'hA000_0000 | i;
    endcase
  endfunction

  // Mem model: combinational 4-word block read, synchronous word write
  assign mem_bus.mem_rdata = {mem_arr[mem_bus.mem_raddr],
                              mem_arr[mem_bus.mem_raddr + 6'd1],
                              mem_arr[mem_bus.mem_raddr + 6'd2],
                              mem_arr[mem_bus.mem_raddr + 6'd3]};

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= mem_init(i);
    end else if (mem_bus.mem_CS && mem_bus.mem_RW) begin
      mem_arr[mem_bus.mem_waddr] <= mem_bus.mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(cpu_bus.cpu_ready), 0);
    chk({tag, "_rdata"}, 64'(cpu_bus.cpu_rdata), 0);
    chk({tag, "_cs"},    64'(mem_bus.mem_CS), 0);
    chk({tag, "_rw"},    64'(mem_bus.mem_RW), 0);
    chk({tag, "_raddr"}, 64'(mem_bus.mem_raddr), 0);
    chk({tag, "_waddr"}, 64'(mem_bus.mem_waddr), 0);
    chk({tag, "_wdata"}, 64'(mem_bus.mem_wdata), 0);
    chk({tag, "_hits"},  64'(hit_count), 0);
    chk({tag, "_miss"},  64'(miss_count), 0);
  endtask

  // One CPU transaction: expectation pushed at drive, popped at cpu_ready
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic hit,
                        input logic [DW-1:0] rdata);
    exp_t          e;
    exp_t          got;
    int            edges;
    int            cs_cycles;
    logic          fill_seen;
    logic [AW-1:0] raddr_s;
    logic [AW-1:0] waddr_s;
    logic [DW-1:0] wdata_s;

    if (hit) exp_hits++;
    else     exp_misses++;
    e.we        = we;
    e.rdata     = rdata;
    e.lat       = (we || !hit) ? 3 : 2;
    e.cs_cycles = (we || !hit) ? 1 : 0;
    e.fill      = !we && !hit;
    e.raddr     = {addr[5:2], 2'b00};
    e.waddr     = addr;
    e.wdata     = wdata;
    e.hits      = 16'(exp_hits);
    e.misses    = 16'(exp_misses);
    sb.push_back(e);

    @(negedge clk);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble the bus after acceptance: the request must be latched
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = ~we;
    cpu_bus.cpu_addr  = ~addr;
    cpu_bus.cpu_wdata = ~wdata;

    edges     = 1;
    cs_cycles = 0;
    fill_seen = 1'b0;
    raddr_s   = '0;
    waddr_s   = '0;
    wdata_s   = '0;
    while (!cpu_bus.cpu_ready && edges < 12) begin
      if (mem_bus.mem_CS) begin
        cs_cycles++;
        if (mem_bus.mem_RW) begin
          waddr_s = mem_bus.mem_waddr;
          wdata_s = mem_bus.mem_wdata;
        end else begin
          fill_seen = 1'b1;
          raddr_s   = mem_bus.mem_raddr;
        end
      end
      @(posedge clk);
      #1;
      edges++;
    end
    if (!cpu_bus.cpu_ready) chk("ready_timeout", 0, 1);

    got = sb.pop_front();
    chk("latency",   64'(edges), 64'(got.lat));
    chk("cs_cycles", 64'(cs_cycles), 64'(got.cs_cycles));
    chk("fill_seen", 64'(fill_seen), 64'(got.fill));
    chk("done_cs",   64'(mem_bus.mem_CS), 0);
    chk("hit_count", 64'(hit_count), 64'(got.hits));
    chk("miss_count",64'(miss_count), 64'(got.misses));
    if (got.fill) chk("fill_raddr", 64'(raddr_s), 64'(got.raddr));
    if (got.we) begin
      chk("wr_addr", 64'(waddr_s), 64'(got.waddr));
      chk("wr_data", 64'(wdata_s), 64'(got.wdata));
    end else begin
      chk("rdata", 64'(cpu_bus.cpu_rdata), 64'(got.rdata));
    end
    @(posedge clk);   // DONE -> IDLE
  endtask

  vec_t vecs [14];
  int   ready_seen;

  initial begin
    total      = 0;
    bad        = 0;
    exp_hits   = 0;
    exp_misses = 0;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;
    reset    = 1'b0;
    mem_load = 1'b1;

    //                 we     addr   wdata          hit   rdata
    vecs[0]  = '{1'b0, 6'h09, 32'h0,         1'b0, 32'h0000_0022};
    vecs[1]  = '{1'b0, 6'h0B, 32'h0,         1'b1, 32'h0000_0044};
    vecs[2]  = '{1'b1, 6'h0A, 32'h0000_DEAD, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 6'h0A, 32'h0,         1'b1, 32'h0000_DEAD};
    vecs[4]  = '{1'b0, 6'h18, 32'h0,         1'b0, 32'h0000_1818};
    vecs[5]  = '{1'b0, 6'h08, 32'h0,         1'b1, 32'h0000_0011};
    vecs[6]  = '{1'b0, 6'h28, 32'h0,         1'b0, 32'h0000_2828};
    vecs[7]  = '{1'b0, 6'h08, 32'h0,         1'b1, 32'h0000_0011};
    vecs[8]  = '{1'b0, 6'h18, 32'h0,         1'b0, 32'h0000_1818};
    vecs[9]  = '{1'b0, 6'h0A, 32'h0,         1'b1, 32'h0000_DEAD};
    vecs[10] = '{1'b1, 6'h30, 32'h1234_5678, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 6'h30, 32'h0,         1'b0, 32'h1234_5678};
    vecs[12] = '{1'b0, 6'h3F, 32'h0,         1'b0, 32'hA000_003F};
    vecs[13] = '{1'b0, 6'h3C, 32'h0,         1'b1, 32'hA000_003C};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    mem_load = 1'b0;
    reset    = 1'b1;

    // Warm up so the async-reset check has non-zero state to clear
    do_req(1'b0, 6'h20, 32'h0, 1'b0, 32'hA000_0020);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hit, vecs[i].rdata);
    end
    chk("mem_0A", 64'(mem_arr[6'h0A]), 64'h0000_DEAD);
    chk("mem_30", 64'(mem_arr[6'h30]), 64'h1234_5678);

    // Reset dropped while the FILL for 0x38 is on the bus
    @(negedge clk);
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 6'h38;
    @(posedge clk);
    #1;
    cpu_bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_fill_cs",    64'(mem_bus.mem_CS), 1);
    chk("abort_fill_raddr", 64'(mem_bus.mem_raddr), 64'h38);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("abort_rst");
    @(negedge clk);
    reset      = 1'b1;
    ready_seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (cpu_bus.cpu_ready) ready_seen++;
    end
    chk("abort_no_ready", 64'(ready_seen), 0);
    exp_hits   = 0;
    exp_misses = 0;
    do_req(1'b0, 6'h38, 32'h0, 1'b0, 32'hA000_0038);
    do_req(1'b0, 6'h09, 32'h0, 1'b0, 32'h0000_0022);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
